// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and issue/wait/respond sequencer in front of the synchronous ALU
// Optional feature macro: ALU_SEQ_FLAGS_EN (captures ALU status flags into rsp_flags)
module alu_cmd_sequencer #(
    parameter int Width   = 4,
    parameter int LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [Width-1:0]     cmd_a,
    input  logic [Width-1:0]     cmd_b,
    input  logic [Width-1:0]     cmd_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*Width-1:0]   rsp_data,
    output logic                 rsp_err,
    output logic [4:0]           rsp_flags,
    output logic [Width-1:0]     alu_a,
    output logic [Width-1:0]     alu_b,
    output logic [Width-1:0]     alu_op,
    output logic                 alu_en,
    input  logic [2*Width-1:0]   alu_res,
    input  logic                 alu_cout,
    input  logic                 alu_borrow,
    input  logic                 alu_gt,
    input  logic                 alu_eq,
    input  logic                 alu_lt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e             state_q, state_d;
    logic [Width-1:0]   fifo_a_q  [2];
    logic [Width-1:0]   fifo_b_q  [2];
    logic [Width-1:0]   fifo_op_q [2];
    logic               wr_ptr_q, rd_ptr_q;
    logic [1:0]         count_q;
    logic [3:0]         cnt_q, cnt_d;
    logic [Width-1:0]   alu_a_q, alu_b_q, alu_op_q;
    logic               illegal_q;
    logic [2*Width-1:0] rsp_data_q;
    logic               rsp_err_q;

    logic push, pop, head_legal, capture, reject;

    assign cmd_ready  = (count_q < 2'd2);
    assign push       = cmd_valid && cmd_ready;
    // Codes above 9, including any nonzero upper opcode bit, are illegal.
    assign head_legal = (fifo_op_q[rd_ptr_q] <= Width'(9));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        alu_en    = 1'b0;
        rsp_valid = 1'b0;
        capture   = 1'b0;
        reject    = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != 2'd0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // An illegal head spends this cycle decoding and never enables the ALU.
                if (illegal_q) begin
                    reject  = 1'b1;
                    state_d = RESP;
                end else begin
                    alu_en  = 1'b1;
                    cnt_d   = 4'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    capture = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_q[wr_ptr_q]  <= cmd_a;
            fifo_b_q[wr_ptr_q]  <= cmd_b;
            fifo_op_q[wr_ptr_q] <= cmd_op;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            illegal_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                rd_ptr_q  <= ~rd_ptr_q;
                illegal_q <= !head_legal;
                // ALU inputs keep the last legally issued command.
                if (head_legal) begin
                    alu_a_q  <= fifo_a_q[rd_ptr_q];
                    alu_b_q  <= fifo_b_q[rd_ptr_q];
                    alu_op_q <= fifo_op_q[rd_ptr_q];
                end
            end
            if (capture) begin
                rsp_data_q <= alu_res;
                rsp_err_q  <= 1'b0;
            end else if (reject) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b1;
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic [4:0] flags_q;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            flags_q <= 5'd0;
        end else if (capture) begin
            flags_q <= {alu_cout, alu_borrow, alu_gt, alu_eq, alu_lt};
        end else if (reject) begin
            flags_q <= 5'd0;
        end
    end

    assign rsp_flags = flags_q;
`else
    logic unused_flags;

    assign unused_flags = &{1'b0, alu_cout, alu_borrow, alu_gt, alu_eq, alu_lt};
    assign rsp_flags    = 5'd0;
`endif

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer with a behavioural ALU stub
module tb_alu_cmd_sequencer;

`ifdef ALU_SEQ_FLAGS_EN
    localparam logic FLAGS_ON = 1'b1;
`else
    localparam logic FLAGS_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_a = '0, cmd_b = '0, cmd_op = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [4:0] rsp_flags;
    logic [3:0] alu_a, alu_b, alu_op;
    logic       alu_en;
    logic [7:0] alu_res = '0;
    logic       alu_cout = 1'b0, alu_borrow = 1'b0, alu_gt = 1'b0, alu_eq = 1'b0, alu_lt = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_data  [$];
    logic [4:0] got_flags [$];
    int         got_cyc   [$];

    alu_cmd_sequencer #(.Width(4), .LATENCY(1)) dut (
        .clk(clk), .arst(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
        .alu_res(alu_res),
        .alu_cout(alu_cout), .alu_borrow(alu_borrow),
        .alu_gt(alu_gt), .alu_eq(alu_eq), .alu_lt(alu_lt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        case (op)
            4'd0: return {4'b0, a} + {4'b0, b};
            4'd1: return {4'b0, a} - {4'b0, b};
            4'd2: return {4'b0, a & b};
            4'd3: return {4'b0, a | b};
            4'd4: return {4'b0, a ^ b};
            4'd5: return {7'b0, a == b};
            4'd6: return {4'b0, a} * {4'b0, b};
            4'd7: return (b != 0) ? {4'b0, a / b} : 8'h00;
            4'd8: return {4'b0, a} << b;
            4'd9: return {4'b0, a} >> b;
            default: return 8'h00;
        endcase
    endfunction

    // Registered ALU with one cycle of latency from the issue cycle.
    always @(posedge clk) begin
        if (alu_en) begin
            alu_res    <= alu_f(alu_a, alu_b, alu_op);
            alu_cout   <= (alu_op == 4'd0) && (({1'b0, alu_a} + {1'b0, alu_b}) > 5'd15);
            alu_borrow <= (alu_op == 4'd1) && (alu_a < alu_b);
            alu_gt     <= alu_a > alu_b;
            alu_eq     <= alu_a == alu_b;
            alu_lt     <= alu_a < alu_b;
        end
    end

    function automatic logic [4:0] fx(input logic [4:0] f);
        return FLAGS_ON ? f : 5'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        int t = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input int n, input int budget);
        int t = 0;
        while (got_data.size() < n && t < budget) begin
            if (rsp_valid && rsp_ready) begin
                got_data.push_back(rsp_data);
                got_flags.push_back(rsp_flags);
                got_cyc.push_back(t);
            end
            @(negedge clk);
            t++;
        end
        check("collect_count", got_data.size(), n);
    endtask

    task automatic run_one(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] op, input logic [7:0] exp_data, input logic exp_err,
                           input int exp_lat, input logic [4:0] exp_flags);
        int cyc = 0;
        int en_cnt = 0;
        int en_cyc = -1;
        send(a, b, op);
        while (!rsp_valid && cyc < 50) begin
            if (alu_en) begin
                en_cnt++;
                en_cyc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_en_cnt"}, en_cnt, exp_err ? 0 : 1);
        check({tag, "_en_cyc"}, en_cyc, exp_err ? -1 : 1);
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_err"}, rsp_err, exp_err);
        check({tag, "_flags"}, rsp_flags, fx(exp_flags));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_rsp_done"}, rsp_valid, 1'b0);
    endtask

    initial begin
        int seen;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_flags", rsp_flags, 5'h00);
        check("rst_alu_abop", {alu_a, alu_b, alu_op}, 12'h000);
        check("rst_alu_en", alu_en, 1'b0);
        arst = 1'b1;
        @(negedge clk);

        // Single commands: {cout, borrow, gt, eq, lt} flags
        run_one("add_3_5",  4'd3, 4'd5, 4'd0, 8'h08, 1'b0, 3, 5'b00001);
        run_one("ill_C",    4'd3, 4'd5, 4'hC, 8'h00, 1'b1, 2, 5'b00000);
        run_one("ill_A",    4'd1, 4'd1, 4'hA, 8'h00, 1'b1, 2, 5'b00000);
        run_one("shr_8_2",  4'd8, 4'd2, 4'd9, 8'h02, 1'b0, 3, 5'b00100);
        run_one("eq_7_7",   4'd7, 4'd7, 4'd5, 8'h01, 1'b0, 3, 5'b00010);
        check("ill_alu_hold", {alu_a, alu_b, alu_op}, 12'h775);

        // Back-to-back with consumer always ready
        rsp_ready = 1'b1;
        got_data.delete(); got_flags.delete(); got_cyc.delete();
        fork
            begin
                send(4'hF, 4'hF, 4'd6);
                send(4'h2, 4'h5, 4'd1);
                send(4'hA, 4'h5, 4'd4);
            end
            collect(3, 200);
        join
        if (got_data.size() == 3) begin
            check("b2b_mul", got_data[0], 8'hE1);
            check("b2b_sub", got_data[1], 8'hFD);
            check("b2b_sub_flags", got_flags[1], fx(5'b01001));
            check("b2b_xor", got_data[2], 8'h0F);
            check("b2b_gap1", got_cyc[1] - got_cyc[0], 4);
            check("b2b_gap2", got_cyc[2] - got_cyc[1], 4);
        end
        rsp_ready = 1'b0;
        @(negedge clk);

        // Backpressure: FIFO fills, then drains in order
        send(4'd1, 4'd2, 4'd0);
        send(4'hC, 4'hA, 4'd2);
        send(4'h5, 4'h2, 4'd3);
        repeat (6) @(negedge clk);
        check("bp_cmd_ready", cmd_ready, 1'b0);
        check("bp_rsp_valid", rsp_valid, 1'b1);
        check("bp_head_data", rsp_data, 8'h03);
        cmd_a = 4'd9; cmd_b = 4'd9; cmd_op = 4'd0; cmd_valid = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (cmd_ready) seen++;
        end
        cmd_valid = 1'b0;
        check("bp_full_hold", seen, 0);
        rsp_ready = 1'b1;
        got_data.delete(); got_flags.delete(); got_cyc.delete();
        collect(3, 200);
        if (got_data.size() == 3) begin
            check("bp_drain0", got_data[0], 8'h03);
            check("bp_drain1", got_data[1], 8'h08);
            check("bp_drain2", got_data[2], 8'h07);
        end
        @(negedge clk);
        check("bp_empty_ready", cmd_ready, 1'b1);

        // Reset during WAIT with two commands queued
        rsp_ready = 1'b0;
        send(4'd3, 4'd3, 4'd6);
        send(4'd1, 4'd1, 4'd0);
        send(4'd2, 4'd2, 4'd0);
        check("pre_rst_full", cmd_ready, 1'b0);
        arst = 1'b0;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_rsp_data", rsp_data, 8'h00);
        check("mid_rst_alu", {alu_a, alu_b, alu_op, alu_en}, 13'h0000);
        @(negedge clk);
        arst = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid || alu_en) seen++;
        end
        check("post_rst_quiet", seen, 0);
        rsp_ready = 1'b0;

        run_one("after_rst_add", 4'd4, 4'd4, 4'd0, 8'h08, 1'b0, 3, 5'b00010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
